mem_wait_ctrl: RTL and testbench
================================

// Module: mem_wait_ctrl
// PURPOSE
//  Unified instruction/data memory with controller, directly downstream of the processor datapath memory port.
//  Accepts the memread/memwrite request the CU issues, inserts WAIT_STATES wait cycles and performs the array access.
//  Signals completion with a one-cycle mem_ready pulse so the CU can hold its memory state until the access is done.
// PARAMETERS
//  DATA_W       16    word width, bits
//  ADDR_W       12    request address width, bits
//  DEPTH        1024  words in array; power of 2, <= 2**ADDR_W
//  WAIT_STATES  2     wait cycles inserted before each array access (0..15)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  memread    in   1       read request; held by requester until mem_ready
//  memwrite   in   1       write request; held by requester until mem_ready
//  addr       in   ADDR_W  word address
//  wdata      in   DATA_W  write data
//  rdata      out  DATA_W  read data; valid with mem_ready, held until next read completes
//  mem_ready  out  1       one-cycle completion pulse
//  busy       out  1       high whenever state != IDLE
//  err        out  1       sticky: read and write requested together
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): state=IDLE, mem_ready=0, rdata=0, busy=0, err=0, wait counter=0.
//    Array contents are not reset. Reset mid-access aborts it; a pending write is NOT committed.
//  - FSM IDLE -> WAIT -> ACCESS -> RESP -> IDLE.
//    IDLE: if memread|memwrite, latch op/addr/wdata, load counter=WAIT_STATES -> WAIT (-> ACCESS if WAIT_STATES=0).
//    WAIT: decrement counter; at 0 -> ACCESS. ACCESS: array read or write -> RESP.
//    RESP: mem_ready=1 for exactly one cycle, rdata updated for reads -> IDLE.
//  - Latency: request first visible in cycle t -> mem_ready high in cycle t+WAIT_STATES+2.
//    Next request accepted earliest cycle t+WAIT_STATES+3.
//  - Request inputs are latched at acceptance; changes while busy are ignored.
//  - memread&memwrite in IDLE: err set (sticky until rst), read performed, write dropped.
//  - Address: index = addr mod DEPTH (low log2(DEPTH) bits); upper bits ignored, no error.
//  - Writes leave rdata unchanged.
// CONFIGURATION
//  Macro MEM_WBUF_EN: one-entry posted write buffer.
//  - With it: write accepted in IDLE with buffer empty is captured, mem_ready pulses at t+1.
//    Buffer drains to the array in background over WAIT_STATES+1 cycles.
//    Any request arriving while the buffer is non-empty waits until drained, then proceeds with normal latency.
//    busy reflects buffer occupancy. Reset empties the buffer without committing it.
//  - Without it: writes use the full FSM latency above; no buffer logic is present.
// STRUCTURE
//  - Package mem_pkg: state enum (IDLE, WAIT, ACCESS, RESP), WAIT_CNT_W=4, default DATA_W/ADDR_W/DEPTH constants.
//  - Sub-module mem_array: single-port synchronous RAM (DEPTH x DATA_W).
//    One-cycle read; write on we. Instantiated once; FSM and optional buffer stay in mem_wait_ctrl.
// TESTING
//  1. Reset: hold rst 2 cycles mid-operation.
//     -> mem_ready=0, rdata=0, busy=0, err=0 next cycle.
//  2. WAIT_STATES=2: write 0x1234 @5 at cycle t, then read @5.
//     -> each mem_ready at request cycle+4; rdata=0x1234.
//  3. memread=memwrite=1 @7 holding 0xBEEF, array[7]=0x0011.
//     -> err=1, rdata=0x0011, array[7] unchanged.
//  4. DEPTH=1024: write 0xA5A5 @0x405, read @0x005.
//     -> rdata=0xA5A5.
//  5. rst asserted in WAIT of a write of 0x7777 @9 (array[9]=0).
//     -> IDLE, no mem_ready; later read @9 returns 0.
//  6. MEM_WBUF_EN, WAIT_STATES=2: write 0x55AA @3 at t, read @3 immediately after.
//     -> write mem_ready at t+1; read waits for drain, then returns 0x55AA after normal latency.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the wait-state memory controller and its array.
package mem_pkg;

    localparam int WAIT_CNT_W      = 4;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ADDR_W      = 12;
    localparam int DEF_DEPTH       = 1024;
    localparam int DEF_WAIT_STATES = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with a registered read port that only updates on reads.
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= din;
        end
    end

    // The read register doubles as the held rdata value, so only reset and reads touch it.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (re) begin
            dout <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_wait_ctrl.sv
// Unified memory controller: inserts WAIT_STATES wait cycles before each array access.
// Optional MEM_WBUF_EN adds a one-entry posted write buffer drained in the background.
module mem_wait_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WS_LOAD = WAIT_CNT_W'(WAIT_STATES);

    mem_state_e              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    op_read_q;
    logic [IDX_W-1:0]        idx_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    err_q;

    logic                    fsm_start;
    logic                    fsm_we;
    logic                    fsm_re;
    logic                    fsm_ready;
    logic                    gate_ok;
    logic                    wb_take;

    logic                    arr_we;
    logic                    arr_re;
    logic [IDX_W-1:0]        arr_idx;
    logic [DATA_W-1:0]       arr_din;

    generate
        if (ADDR_W > IDX_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];
        end
    endgenerate

`ifdef MEM_WBUF_EN
    logic                    wb_valid_q;
    logic [WAIT_CNT_W-1:0]   wb_cnt_q;
    logic [IDX_W-1:0]        wb_idx_q;
    logic [DATA_W-1:0]       wb_data_q;
    logic                    wb_ack_q;
    logic                    wb_drain;

    // Pure writes are posted; anything else waits until the buffer has drained.
    assign gate_ok  = !wb_valid_q;
    assign wb_take  = (state_q == IDLE) && gate_ok && memwrite && !memread;
    assign wb_drain = wb_valid_q && (wb_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_cnt_q   <= '0;
            wb_ack_q   <= 1'b0;
        end else begin
            wb_ack_q <= wb_take;
            if (wb_take) begin
                wb_valid_q <= 1'b1;
                wb_cnt_q   <= WS_LOAD;
            end else if (wb_valid_q) begin
                if (wb_cnt_q == '0) begin
                    wb_valid_q <= 1'b0;
                end else begin
                    wb_cnt_q <= wb_cnt_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wb_take) begin
            wb_idx_q  <= addr[IDX_W-1:0];
            wb_data_q <= wdata;
        end
    end

    // The FSM never leaves IDLE while the buffer holds data, so the port is never shared.
    assign arr_we    = !rst && (fsm_we || wb_drain);
    assign arr_idx   = wb_drain ? wb_idx_q : idx_q;
    assign arr_din   = wb_drain ? wb_data_q : wdata_q;
    assign mem_ready = fsm_ready || wb_ack_q;
    assign busy      = (state_q != IDLE) || wb_valid_q;
`else
    assign gate_ok   = 1'b1;
    assign wb_take   = 1'b0;

    assign arr_we    = !rst && fsm_we;
    assign arr_idx   = idx_q;
    assign arr_din   = wdata_q;
    assign mem_ready = fsm_ready;
    assign busy      = (state_q != IDLE);
`endif

    assign fsm_start = (state_q == IDLE) && gate_ok && (memread || memwrite) && !wb_take;
    assign arr_re    = fsm_re;
    assign err       = err_q;

    // WAIT lasts exactly WAIT_STATES cycles; the counter hits zero on the way into ACCESS.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fsm_we    = 1'b0;
        fsm_re    = 1'b0;
        fsm_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fsm_start) begin
                    cnt_d   = WS_LOAD;
                    state_d = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= WAIT_CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACCESS: begin
                fsm_we  = !op_read_q;
                fsm_re  = op_read_q;
                state_d = RESP;
            end
            RESP: begin
                fsm_ready = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (fsm_start && memread && memwrite) begin
                err_q <= 1'b1;
            end
        end
    end

    // A simultaneous read/write is treated as a read; its write data is simply dropped.
    always_ff @(posedge clk) begin
        if (fsm_start) begin
            op_read_q <= memread;
            idx_q     <= addr[IDX_W-1:0];
            wdata_q   <= wdata;
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (arr_we),
        .re   (arr_re),
        .idx  (arr_idx),
        .din  (arr_din),
        .dout (rdata)
    );

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Directed self-checking bench for mem_wait_ctrl (WAIT_STATES=2, DEPTH=1024).
// Write and post-write latencies follow MEM_WBUF_EN when it is defined.
module tb_mem_wait_ctrl;

    localparam int WS = 2;
    localparam int RD_LAT = WS + 2;
`ifdef MEM_WBUF_EN
    localparam int WR_LAT = 1;
    localparam int AFTER_WR_LAT = 2 * WS + 2;
`else
    localparam int WR_LAT = WS + 2;
    localparam int AFTER_WR_LAT = WS + 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        memread;
    logic        memwrite;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        mem_ready;
    logic        busy;
    logic        err;

    int compared = 0;
    int mismatched = 0;
    int lat;
    logic [15:0] rv;

    mem_wait_ctrl #(
        .DATA_W      (16),
        .ADDR_W      (12),
        .DEPTH       (1024),
        .WAIT_STATES (WS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .memread   (memread),
        .memwrite  (memwrite),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [11:0] a, input logic [15:0] d);
        memread  = rd;
        memwrite = wr;
        addr     = a;
        wdata    = d;
    endtask

    // Counts cycles from the current one until mem_ready, bounded.
    task automatic waitReady(input string tag, output int l, output logic [15:0] r);
        l = -1;
        r = '0;
        for (int k = 0; k < 64; k++) begin
            if (mem_ready) begin
                l = k;
                r = rdata;
                break;
            end
            tick();
        end
        checkOutput({tag, "_seen"}, 32'(l >= 0), 32'd1);
    endtask

    // Drives one request, waits for completion, then releases it like the CU would.
    task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                                 input logic [11:0] a, input logic [15:0] d,
                                 output int l, output logic [15:0] r);
        drive(rd, wr, a, d);
        waitReady(tag, l, r);
        tick();
        checkOutput({tag, "_pulse"}, 32'(mem_ready), 32'd0);
        drive(1'b0, 1'b0, 12'h000, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 12'h000, 16'h0000);
        tick();
        tick();
        rst = 1'b0;
        tick();
        $display("[TB] reset state");
        checkOutput("rst_ready", 32'(mem_ready), 32'd0);
        checkOutput("rst_rdata", 32'(rdata), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);

        $display("[TB] write then read @5");
        applyStimulus("wr5", 1'b0, 1'b1, 12'h005, 16'h1234, lat, rv);
        checkOutput("wr5_lat", 32'(lat), 32'(WR_LAT));
        checkOutput("wr5_rdata_kept", 32'(rdata), 32'h0);
        applyStimulus("rd5", 1'b1, 1'b0, 12'h005, 16'h0000, lat, rv);
        checkOutput("rd5_lat", 32'(lat), 32'(AFTER_WR_LAT));
        checkOutput("rd5_data", 32'(rv), 32'h1234);
        checkOutput("rd5_hold", 32'(rdata), 32'h1234);

        $display("[TB] simultaneous read and write @7");
        applyStimulus("wr7", 1'b0, 1'b1, 12'h007, 16'h0011, lat, rv);
        applyStimulus("dual7", 1'b1, 1'b1, 12'h007, 16'hBEEF, lat, rv);
        checkOutput("dual7_lat", 32'(lat), 32'(AFTER_WR_LAT));
        checkOutput("dual7_data", 32'(rv), 32'h0011);
        checkOutput("dual7_err", 32'(err), 32'd1);
        applyStimulus("rd7", 1'b1, 1'b0, 12'h007, 16'h0000, lat, rv);
        checkOutput("rd7_lat", 32'(lat), 32'(RD_LAT));
        checkOutput("rd7_data", 32'(rv), 32'h0011);
        checkOutput("rd7_err_sticky", 32'(err), 32'd1);

        $display("[TB] address wrap at DEPTH");
        applyStimulus("wr405", 1'b0, 1'b1, 12'h405, 16'hA5A5, lat, rv);
        checkOutput("wr405_rdata_kept", 32'(rdata), 32'h0011);
        applyStimulus("rd005", 1'b1, 1'b0, 12'h005, 16'h0000, lat, rv);
        checkOutput("rd005_data", 32'(rv), 32'hA5A5);
        applyStimulus("rd805", 1'b1, 1'b0, 12'h805, 16'h0000, lat, rv);
        checkOutput("rd805_lat", 32'(lat), 32'(RD_LAT));
        checkOutput("rd805_data", 32'(rv), 32'hA5A5);

        $display("[TB] request changes after acceptance are ignored");
        drive(1'b0, 1'b1, 12'h00A, 16'h1111);
        tick();
        drive(1'b0, 1'b1, 12'h00B, 16'h2222);
        waitReady("wr10", lat, rv);
        tick();
        drive(1'b0, 1'b0, 12'h000, 16'h0000);
        applyStimulus("rd10", 1'b1, 1'b0, 12'h00A, 16'h0000, lat, rv);
        checkOutput("rd10_data", 32'(rv), 32'h1111);

        $display("[TB] reset mid-read");
        drive(1'b1, 1'b0, 12'h005, 16'h0000);
        tick();
        tick();
        checkOutput("midrd_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        drive(1'b0, 1'b0, 12'h000, 16'h0000);
        tick();
        checkOutput("midrd_rst_ready", 32'(mem_ready), 32'd0);
        tick();
        rst = 1'b0;
        checkOutput("midrd_ready", 32'(mem_ready), 32'd0);
        checkOutput("midrd_rdata", 32'(rdata), 32'h0);
        checkOutput("midrd_busy_clr", 32'(busy), 32'd0);
        checkOutput("midrd_err_clr", 32'(err), 32'd0);
        tick();
        checkOutput("midrd_idle_ready", 32'(mem_ready), 32'd0);

        $display("[TB] reset during pending write @9");
        applyStimulus("wr9z", 1'b0, 1'b1, 12'h009, 16'h0000, lat, rv);
        for (int i = 0; i < 6; i++) tick();
        drive(1'b0, 1'b1, 12'h009, 16'h7777);
        tick();
        checkOutput("wr9_busy", 32'(busy), 32'd1);
`ifndef MEM_WBUF_EN
        checkOutput("wr9_no_ready", 32'(mem_ready), 32'd0);
`endif
        rst = 1'b1;
        drive(1'b0, 1'b0, 12'h000, 16'h0000);
        tick();
        rst = 1'b0;
        checkOutput("wr9_rst_ready", 32'(mem_ready), 32'd0);
        checkOutput("wr9_rst_busy", 32'(busy), 32'd0);
        tick();
        applyStimulus("rd9", 1'b1, 1'b0, 12'h009, 16'h0000, lat, rv);
        checkOutput("rd9_lat", 32'(lat), 32'(RD_LAT));
        checkOutput("rd9_data", 32'(rv), 32'h0000);

`ifdef MEM_WBUF_EN
        $display("[TB] posted write then immediate read @3");
        drive(1'b0, 1'b1, 12'h003, 16'h55AA);
        waitReady("pw3", lat, rv);
        checkOutput("pw3_lat", 32'(lat), 32'd1);
        tick();
        drive(1'b0, 1'b0, 12'h000, 16'h0000);
        checkOutput("pw3_busy", 32'(busy), 32'd1);
        applyStimulus("prd3", 1'b1, 1'b0, 12'h003, 16'h0000, lat, rv);
        checkOutput("prd3_lat", 32'(lat), 32'(2 * WS + 2));
        checkOutput("prd3_data", 32'(rv), 32'h55AA);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
